ncpu32k_wb_arbiter: RTL and testbench

Writeback stage that collects results from the ALU and LSU, buffers one result per source, arbitrates between them, and drives the single registered write port of the register file. It also answers a combinational pending-write lookup that the issue stage uses to stall on read-after-write hazards.

---
 rtl/ncpu32k_wb_arbiter_pkg.sv | 14 +
 rtl/ncpu32k_wb_slot.sv | 61 ++++++
 rtl/ncpu32k_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_ncpu32k_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncpu32k_wb_arbiter_pkg.sv
// Shared configuration for the ncpu32k writeback arbiter: register address
// width, data width and the source encoding used by the round-robin pointer.
package ncpu32k_wb_arbiter_pkg;

    localparam int NCPU_REG_AW = 5;
    localparam int NCPU_DW     = 32;

    // Identifies which source owns the round-robin turn on contention
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/ncpu32k_wb_slot.sv
// One-entry holding register for a writeback source. A load takes priority
// over a grant-clear so a source can stream back-to-back; flush empties the
// slot and drops any load arriving in the same cycle.
module ncpu32k_wb_slot
    import ncpu32k_wb_arbiter_pkg::*;
#(
    parameter int AW = NCPU_REG_AW,
    parameter int DW = NCPU_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          grant_i,
    input  logic          flush_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] dat_i,
    output logic          occ_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] dat_o
);

    logic          occ_d, occ_q;
    logic [AW-1:0] addr_d, addr_q;
    logic [DW-1:0] dat_d, dat_q;

    // Next-state of the slot: flush, then load, then grant-clear
    always_comb begin
        occ_d  = occ_q;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (flush_i) begin
            occ_d = 1'b0;
        end else if (load_i) begin
            occ_d  = 1'b1;
            addr_d = addr_i;
            dat_d  = dat_i;
        end else if (grant_i) begin
            occ_d = 1'b0;
        end else begin
            occ_d = occ_q;
        end
    end

    // Slot state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q  <= 1'b0;
            addr_q <= {AW{1'b0}};
            dat_q  <= {DW{1'b0}};
        end else begin
            occ_q  <= occ_d;
            addr_q <= addr_d;
            dat_q  <= dat_d;
        end
    end

    assign occ_o  = occ_q;
    assign addr_o = addr_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/ncpu32k_wb_arbiter.sv
// Writeback arbiter: buffers one ALU and one LSU result, picks one per cycle
// and drives the registered register-file write port. Also answers the
// pending-write lookup used by issue for RAW stalls.
// Optional feature: define NCPU_WB_RR_ARB_EN for round-robin arbitration;
// otherwise LSU has fixed priority over ALU.
module ncpu32k_wb_arbiter
    import ncpu32k_wb_arbiter_pkg::*;
#(
    parameter int AW = NCPU_REG_AW,
    parameter int DW = NCPU_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alu_valid_i,
    output logic          alu_ready_o,
    input  logic [AW-1:0] alu_addr_i,
    input  logic [DW-1:0] alu_dat_i,
    input  logic          lsu_valid_i,
    output logic          lsu_ready_o,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [DW-1:0] lsu_dat_i,
    input  logic          flush_i,
    input  logic [AW-1:0] chk_addr_i,
    output logic          chk_hit_o,
    output logic          rd_we_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [DW-1:0] rd_o
);

    logic          alu_occ_s, lsu_occ_s;
    logic [AW-1:0] alu_addr_s, lsu_addr_s;
    logic [DW-1:0] alu_dat_s, lsu_dat_s;
    logic          alu_win_s, lsu_win_s, contended_s;
    logic          alu_grant_s, lsu_grant_s;
    logic          alu_load_s, lsu_load_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_dat_s;

    logic          rd_we_d, rd_we_q;
    logic [AW-1:0] rd_addr_d, rd_addr_q;
    logic [DW-1:0] rd_d, rd_q;

    assign contended_s = alu_occ_s & lsu_occ_s;

`ifdef NCPU_WB_RR_ARB_EN
    wb_src_e rr_ptr_d, rr_ptr_q;

    // Pointer hands the next contended turn to the other source
    always_comb begin
        if (contended_s & ~flush_i) begin
            rr_ptr_d = (rr_ptr_q == SRC_LSU) ? SRC_ALU : SRC_LSU;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register, LSU owns the first contended turn
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= SRC_LSU;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Winner selection purely from registered slot state
    always_comb begin
        alu_win_s = 1'b0;
        lsu_win_s = 1'b0;
        if (contended_s) begin
`ifdef NCPU_WB_RR_ARB_EN
            lsu_win_s = (rr_ptr_q == SRC_LSU);
            alu_win_s = (rr_ptr_q == SRC_ALU);
`else
            lsu_win_s = 1'b1;
            alu_win_s = 1'b0;
`endif
        end else begin
            alu_win_s = alu_occ_s;
            lsu_win_s = lsu_occ_s;
        end
    end

    // ready only looks at the would-be winner, so it never depends on flush or valid
    assign alu_ready_o = ~alu_occ_s | alu_win_s;
    assign lsu_ready_o = ~lsu_occ_s | lsu_win_s;
    assign alu_grant_s = alu_win_s & ~flush_i;
    assign lsu_grant_s = lsu_win_s & ~flush_i;
    assign alu_load_s  = alu_valid_i & alu_ready_o;
    assign lsu_load_s  = lsu_valid_i & lsu_ready_o;
    assign win_addr_s  = lsu_win_s ? lsu_addr_s : alu_addr_s;
    assign win_dat_s   = lsu_win_s ? lsu_dat_s : alu_dat_s;

    ncpu32k_wb_slot #(.AW(AW), .DW(DW)) u_alu_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (alu_load_s),
        .grant_i (alu_grant_s),
        .flush_i (flush_i),
        .addr_i  (alu_addr_i),
        .dat_i   (alu_dat_i),
        .occ_o   (alu_occ_s),
        .addr_o  (alu_addr_s),
        .dat_o   (alu_dat_s)
    );

    ncpu32k_wb_slot #(.AW(AW), .DW(DW)) u_lsu_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lsu_load_s),
        .grant_i (lsu_grant_s),
        .flush_i (flush_i),
        .addr_i  (lsu_addr_i),
        .dat_i   (lsu_dat_i),
        .occ_o   (lsu_occ_s),
        .addr_o  (lsu_addr_s),
        .dat_o   (lsu_dat_s)
    );

    // Write port next-state: pulse on grant, r0 writes load address/data but not enable
    always_comb begin
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        if (alu_grant_s | lsu_grant_s) begin
            rd_we_d   = (win_addr_s != {AW{1'b0}});
            rd_addr_d = win_addr_s;
            rd_d      = win_dat_s;
        end else begin
            rd_we_d = 1'b0;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_we_q   <= 1'b0;
            rd_addr_q <= {AW{1'b0}};
            rd_q      <= {DW{1'b0}};
        end else begin
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
        end
    end

    assign rd_we_o   = rd_we_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_o      = rd_q;

    assign chk_hit_o = (chk_addr_i != {AW{1'b0}}) &
                       ((alu_occ_s & (alu_addr_s == chk_addr_i)) |
                        (lsu_occ_s & (lsu_addr_s == chk_addr_i)) |
                        (rd_we_q   & (rd_addr_q  == chk_addr_i)));

endmodule

// File: tb/tb_ncpu32k_wb_arbiter.sv
// Self-checking bench for ncpu32k_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ncpu32k_wb_arbiter;
    import ncpu32k_wb_arbiter_pkg::*;

    localparam int AW = NCPU_REG_AW;
    localparam int DW = NCPU_DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0] alu_addr, lsu_addr, chk_addr, rd_addr;
    logic [DW-1:0] alu_dat, lsu_dat, rd_dat;
    logic          flush, chk_hit, rd_we;

    int n_checks = 0;
    int n_fail   = 0;

    ncpu32k_wb_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
        .alu_addr_i(alu_addr), .alu_dat_i(alu_dat),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_addr_i(lsu_addr), .lsu_dat_i(lsu_dat),
        .flush_i(flush), .chk_addr_i(chk_addr), .chk_hit_o(chk_hit),
        .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_o(rd_dat)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (index 0 = ALU, 1 = LSU) ----------------
    logic          m_occ [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_dat [2];
    int            m_turn;       // source that wins the next contention
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdat;

    function automatic void m_reset();
        for (int s = 0; s < 2; s++) m_occ[s] = 1'b0;
        m_turn = 1; m_we = 1'b0; m_waddr = '0; m_wdat = '0;
    endfunction

    function automatic int m_winner();
        if (m_occ[0] && m_occ[1]) begin
`ifdef NCPU_WB_RR_ARB_EN
            return m_turn;
`else
            return 1;
`endif
        end
        if (m_occ[1]) return 1;
        if (m_occ[0]) return 0;
        return -1;
    endfunction

    function automatic logic m_ready(input int s);
        return !m_occ[s] || (m_winner() == s);
    endfunction

    function automatic logic m_hit(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        return (m_occ[0] && m_addr[0] == a) || (m_occ[1] && m_addr[1] == a) ||
               (m_we && m_waddr == a);
    endfunction

    function automatic void m_advance(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                      input logic fl);
        int   w;
        logic both, r0, r1;
        w = m_winner(); both = m_occ[0] && m_occ[1];
        r0 = m_ready(0); r1 = m_ready(1);
        m_we = 1'b0;
        if (fl) begin
            m_occ[0] = 1'b0; m_occ[1] = 1'b0;
        end else begin
            if (w >= 0) begin
                m_we = (m_addr[w] != '0); m_waddr = m_addr[w]; m_wdat = m_dat[w];
                m_occ[w] = 1'b0;
                if (both) m_turn = 1 - m_turn;
            end
            if (av && r0) begin m_occ[0] = 1'b1; m_addr[0] = aa; m_dat[0] = ad; end
            if (lv && r1) begin m_occ[1] = 1'b1; m_addr[1] = la; m_dat[1] = ld; end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_dat = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_dat = '0;
        flush = 1'b0; chk_addr = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        chk_addr = 5'd3; #1;
        n_checks++;
        if ({rd_we, rd_addr, rd_dat} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL reset_wport: got %h expected 0", {rd_we, rd_addr, rd_dat});
        end
        n_checks++;
        if ({alu_ready, lsu_ready, chk_hit} !== 3'b110) begin
            n_fail++; $display("FAIL reset_ready_hit: got %b expected 110", {alu_ready, lsu_ready, chk_hit});
        end
    endtask

    task automatic test_single();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_dat = 32'h1234; #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", alu_ready); end
        step(); alu_valid = 1'b0;
        n_checks++;
        if (rd_we !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", rd_we); end
        step();
        n_checks++;
        if ({rd_we, rd_addr, rd_dat} !== {1'b1, 5'd5, 32'h1234}) begin
            n_fail++; $display("FAIL single_write: got %h expected %h", {rd_we, rd_addr, rd_dat}, {1'b1, 5'd5, 32'h1234});
        end
        step();
        n_checks++;
        if (rd_we !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", rd_we); end
    endtask

    task automatic test_contention();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_dat = 32'hA;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_dat = 32'hB;
        step(); idle_inputs(); #1;
        n_checks++;
        if ({alu_ready, lsu_ready} !== 2'b01) begin
            n_fail++; $display("FAIL cont_ready: got %b expected 01", {alu_ready, lsu_ready});
        end
        step();
        n_checks++;
        if ({rd_we, rd_addr, rd_dat, alu_ready} !== {1'b1, 5'd4, 32'hB, 1'b1}) begin
            n_fail++; $display("FAIL cont_first: got %h expected %h", {rd_we, rd_addr, rd_dat, alu_ready}, {1'b1, 5'd4, 32'hB, 1'b1});
        end
        step();
        n_checks++;
        if ({rd_we, rd_addr, rd_dat} !== {1'b1, 5'd3, 32'hA}) begin
            n_fail++; $display("FAIL cont_second: got %h expected %h", {rd_we, rd_addr, rd_dat}, {1'b1, 5'd3, 32'hA});
        end
        alu_valid = 1'b1; alu_addr = 5'd6; alu_dat = 32'hC;
        lsu_valid = 1'b1; lsu_addr = 5'd8; lsu_dat = 32'hD;
        step(); idle_inputs();
        step();
`ifdef NCPU_WB_RR_ARB_EN
        n_checks++;
        if ({rd_addr, rd_dat} !== {5'd6, 32'hC}) begin
            n_fail++; $display("FAIL cont_rr_turn: got %h expected %h", {rd_addr, rd_dat}, {5'd6, 32'hC});
        end
`else
        n_checks++;
        if ({rd_addr, rd_dat} !== {5'd8, 32'hD}) begin
            n_fail++; $display("FAIL cont_fixed_again: got %h expected %h", {rd_addr, rd_dat}, {5'd8, 32'hD});
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] dats[8];
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                dats[i] = $urandom;
                alu_valid = 1'b1; alu_addr = 5'(i + 1); alu_dat = dats[i]; #1;
                n_checks++;
                if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, alu_ready); end
            end else begin
                alu_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                n_checks++;
                if ({rd_we, rd_addr, rd_dat} !== {1'b1, 5'(i), dats[i - 1]}) begin
                    n_fail++; $display("FAIL b2b_write[%0d]: got %h expected %h", i, {rd_we, rd_addr, rd_dat}, {1'b1, 5'(i), dats[i - 1]});
                end
            end
        end
        step();
        n_checks++;
        if (rd_we !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", rd_we); end
    endtask

    task automatic test_r0();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_dat = 32'h55; chk_addr = 5'd0;
        step(); alu_valid = 1'b0; #1;
        n_checks++;
        if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL r0_hit: got %b expected 0", chk_hit); end
        step();
        n_checks++;
        if ({rd_we, rd_addr, rd_dat} !== {1'b0, 5'd0, 32'h55}) begin
            n_fail++; $display("FAIL r0_write: got %h expected %h", {rd_we, rd_addr, rd_dat}, {1'b0, 5'd0, 32'h55});
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd2; alu_dat = 32'h1;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_dat = 32'h2; chk_addr = 5'd7; #1;
        n_checks++;
        if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL haz_before: got %b expected 0", chk_hit); end
        step(); alu_valid = 1'b0; lsu_valid = 1'b0; #1;
        n_checks++;
        if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL haz_slot: got %b expected 1", chk_hit); end
        step();
        n_checks++;
        if ({chk_hit, rd_we, rd_addr} !== {1'b1, 1'b1, 5'd7}) begin
            n_fail++; $display("FAIL haz_wport: got %b expected %b", {chk_hit, rd_we, rd_addr}, {1'b1, 1'b1, 5'd7});
        end
        step();
        n_checks++;
        if ({chk_hit, rd_addr} !== {1'b0, 5'd2}) begin
            n_fail++; $display("FAIL haz_after: got %b expected %b", {chk_hit, rd_addr}, {1'b0, 5'd2});
        end
    endtask

    task automatic test_flush();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_dat = 32'h33;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_dat = 32'h44;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_dat = 32'h99; flush = 1'b1;
        step(); idle_inputs(); #1;
        n_checks++;
        if ({rd_we, alu_ready, lsu_ready} !== 3'b011) begin
            n_fail++; $display("FAIL flush_now: got %b expected 011", {rd_we, alu_ready, lsu_ready});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (rd_we !== 1'b0) begin n_fail++; $display("FAIL flush_after[%0d]: got %b expected 0", i, rd_we); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_dat = 32'hDEAD;
        lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_dat = 32'hBEEF;
        step(); step();
        n_checks++;
        if ({rd_we, rd_addr} !== {1'b1, 5'd10}) begin
            n_fail++; $display("FAIL arst_pre: got %b expected %b", {rd_we, rd_addr}, {1'b1, 5'd10});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_we, rd_addr, rd_dat, alu_ready, lsu_ready} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL arst_clear: got %h expected %h", {rd_we, rd_addr, rd_dat, alu_ready, lsu_ready}, {1'b0, 5'd0, 32'd0, 1'b1, 1'b1});
        end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        m_reset();
        for (int i = 0; i < 600; i++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = AW'($urandom_range(0, 7));
            alu_dat   = $urandom;
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_addr  = AW'($urandom_range(0, 7));
            lsu_dat   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            chk_addr  = AW'($urandom_range(0, 7));
            #1;
            n_checks++;
            if ({alu_ready, lsu_ready, chk_hit} !== {m_ready(0), m_ready(1), m_hit(chk_addr)}) begin
                n_fail++; $display("FAIL rand_comb[%0d]: got %b expected %b", i, {alu_ready, lsu_ready, chk_hit}, {m_ready(0), m_ready(1), m_hit(chk_addr)});
            end
            m_advance(alu_valid, alu_addr, alu_dat, lsu_valid, lsu_addr, lsu_dat, flush);
            step();
            n_checks++;
            if ({rd_we, rd_addr, rd_dat} !== {m_we, m_waddr, m_wdat}) begin
                n_fail++; $display("FAIL rand_wport[%0d]: got %h expected %h", i, {rd_we, rd_addr, rd_dat}, {m_we, m_waddr, m_wdat});
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_r0();
        test_hazard();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
